// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - shared types and constants for the key ROM burst controller
package key_ctrl_pkg;

  localparam int ROM_DEPTH      = 32;
  localparam int KEY_ADDR_BITS  = $clog2(ROM_DEPTH);
  localparam int KEY_DATA_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at index ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int j;

  // Walk from ptr upward with wrap; the first set request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/key_rom_ctrl.sv
// rtl/key_rom_ctrl.sv - burst-read controller and round-robin arbiter for the key ROM
module key_rom_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_BITS  = KEY_ADDR_BITS,
  parameter int DATA_WIDTH = KEY_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_len,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic [DATA_WIDTH-1:0]          key_data,
  output logic                           key_valid,
  output logic                           key_last,
  output logic                           busy,
  output logic                           rom_en,
  output logic [ADDR_BITS-1:0]           rom_addr,
  input  logic [DATA_WIDTH-1:0]          rom_dout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        win_idx;
  logic [ADDR_BITS-1:0] cnt;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [ADDR_BITS-1:0] sel_len;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // ROM data passes straight through; validity is qualified by key_valid.
  assign key_data = rom_dout;
  assign busy     = (state != IDLE);

  // Pick the winner's start address and length out of the packed request fields.
  always_comb begin
    sel_addr = req_addr[int'(arb_idx)*ADDR_BITS +: ADDR_BITS];
    sel_len  = req_len[int'(arb_idx)*ADDR_BITS +: ADDR_BITS];
  end

  // Controller FSM: arbitrate in IDLE, issue addresses in BURST, deliver last word in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win_idx   <= '0;
      cnt       <= '0;
      grant     <= '0;
      done      <= '0;
      key_valid <= 1'b0;
      key_last  <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
    end else begin
      // The ROM answers one cycle after each enabled read.
      key_valid <= rom_en;
      case (state)
        IDLE: begin
          done     <= '0;
          key_last <= 1'b0;
          if (arb_any) begin
            state    <= BURST;
            grant    <= arb_gnt;
            win_idx  <= arb_idx;
            rom_en   <= 1'b1;
            rom_addr <= sel_addr;
            cnt      <= sel_len;
          end
        end
        BURST: begin
          if (cnt == '0) begin
            state    <= DRAIN;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            key_last <= 1'b1;
            done     <= grant;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            cnt      <= cnt - 1'b1;
          end
        end
        DRAIN: begin
          state    <= IDLE;
          grant    <= '0;
          done     <= '0;
          key_last <= 1'b0;
          ptr      <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_rom_ctrl.sv
// tb/tb_key_rom_ctrl.sv - self-checking bench for key_rom_ctrl with a behavioural ROM
module tb_key_rom_ctrl;

  localparam int N  = 4;
  localparam int AB = 5;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AB-1:0] req_addr;
  logic [N*AB-1:0] req_len;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [DW-1:0]   key_data;
  logic            key_valid;
  logic            key_last;
  logic            busy;
  logic            rom_en;
  logic [AB-1:0]   rom_addr;
  logic [DW-1:0]   rom_dout;

  logic [DW-1:0]   rom_mem [32];
  int              checks    = 0;
  int              failures  = 0;
  int              model_ptr = 0;
  int              m_addr [N];
  int              m_len  [N];
  logic [DW-1:0]   first_word;
  logic [DW-1:0]   last_word;
  logic [N-1:0]    last_grant;

  always #5 clk = ~clk;

  key_rom_ctrl #(.NUM_REQ(N), .ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .grant     (grant),
    .done      (done),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_last  (key_last),
    .busy      (busy),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout)
  );

  // Registered ROM: data one cycle after an enabled read, zero otherwise.
  always @(posedge clk) rom_dout <= rom_en ? rom_mem[rom_addr] : '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AB +: AB] = AB'(m_addr[i]);
      req_len[i*AB +: AB]  = AB'(m_len[i]);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // One complete burst, entered and left at the negedge of an IDLE cycle.
  task automatic burst(input logic [N-1:0] r, input bit perturb);
    int w, a, l;
    logic [N-1:0] g;
    req = r;
    drive_fields();
    w = rr_pick(r, model_ptr);
    a = m_addr[w];
    l = m_len[w];
    g = '0;
    g[w] = 1'b1;
    last_grant = g;
    @(posedge clk); @(negedge clk);
    chk("grant_start", DW'(grant), DW'(g));
    chk("busy_start", DW'(busy), DW'(1));
    chk("rom_en_start", DW'(rom_en), DW'(1));
    chk("rom_addr_start", DW'(rom_addr), DW'(a));
    chk("key_valid_start", DW'(key_valid), DW'(0));
    for (int i = 0; i <= l; i++) begin
      if (perturb && i == 0) begin
        req[w] = 1'b0;
        req_addr[w*AB +: AB] = ~AB'(a);
        req_len[w*AB +: AB]  = AB'($urandom_range(0, 31));
      end
      @(posedge clk); @(negedge clk);
      chk("key_valid", DW'(key_valid), DW'(1));
      chk("key_data", key_data, rom_mem[(a + i) % 32]);
      chk("key_last", DW'(key_last), DW'(i == l));
      chk("done", DW'(done), (i == l) ? DW'(g) : DW'(0));
      chk("grant_hold", DW'(grant), DW'(g));
      chk("rom_en", DW'(rom_en), DW'(i < l));
      if (i < l) chk("rom_addr", DW'(rom_addr), DW'((a + i + 1) % 32));
      if (i == 0) first_word = key_data;
      last_word = key_data;
    end
    @(posedge clk); @(negedge clk);
    chk("busy_idle", DW'(busy), DW'(0));
    chk("grant_idle", DW'(grant), DW'(0));
    chk("done_idle", DW'(done), DW'(0));
    chk("key_valid_idle", DW'(key_valid), DW'(0));
    chk("rom_en_idle", DW'(rom_en), DW'(0));
    model_ptr = (w + 1) % N;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rom_mem[2]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rom_mem[4]  = 128'h603deb1015ca71be2b73aef0857d7781;
    rom_mem[30] = 128'h7b0c785e27e8ad3f8223207104725dd4;
    rom_mem[31] = 128'h6bc1bee22e409f96e93d7e117393172a;
    rom_mem[0]  = 128'hf69f2445df4f9b17ad2b417be66c3710;
    for (int i = 0; i < N; i++) begin m_addr[i] = 0; m_len[i] = 0; end
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    req_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", DW'(grant), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_key_valid", DW'(key_valid), DW'(0));
    chk("rst_key_last", DW'(key_last), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_rom_en", DW'(rom_en), DW'(0));
    chk("rst_rom_addr", DW'(rom_addr), DW'(0));
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    // Single word from address 2.
    m_addr[0] = 2; m_len[0] = 0;
    burst(4'b0001, 1'b0);
    chk("single_word", last_word, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Full 32-word burst from address 4.
    m_addr[2] = 4; m_len[2] = 31;
    burst(4'b0100, 1'b0);
    chk("full_first_word", first_word, 128'h603deb1015ca71be2b73aef0857d7781);

    // Late request/address changes during the burst have no effect.
    m_addr[3] = 10; m_len[3] = 5;
    burst(4'b1000, 1'b1);
    m_addr[3] = 10; m_len[3] = 5;

    // Wrap across address 31 to 0.
    m_addr[1] = 30; m_len[1] = 2;
    burst(4'b0010, 1'b0);
    chk("wrap_last_word", last_word, 128'hf69f2445df4f9b17ad2b417be66c3710);
    req = '0;

    // Reset in the middle of a len-7 burst.
    m_addr[2] = 12; m_len[2] = 7;
    req = 4'b0100;
    drive_fields();
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_grant", DW'(grant), DW'(0));
    chk("mid_rst_done", DW'(done), DW'(0));
    chk("mid_rst_key_valid", DW'(key_valid), DW'(0));
    chk("mid_rst_key_last", DW'(key_last), DW'(0));
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_rom_en", DW'(rom_en), DW'(0));
    chk("mid_rst_rom_addr", DW'(rom_addr), DW'(0));
    rst = 1'b0;
    model_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_key_valid", DW'(key_valid), DW'(0));
      chk("post_rst_done", DW'(done), DW'(0));
    end

    // Round-robin with every requester held, single-word bursts: order 0,1,2,3,0.
    for (int i = 0; i < N; i++) begin m_addr[i] = $urandom_range(0, 31); m_len[i] = 0; end
    for (int b = 0; b < 5; b++) begin
      burst(4'b1111, 1'b0);
      chk("rr_order", DW'(last_grant), DW'(4'b0001 << (b % N)));
    end

    // Randomized request mixes, addresses and lengths.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        m_addr[i] = $urandom_range(0, 31);
        m_len[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
      end
      burst(N'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_rom_ctrl.md
Name: key_rom_ctrl

Overview:
- Burst-read controller and round-robin arbiter for the 32x128 key ROM (ROM_key).
- Up to NUM_REQ cipher engines each request a run of consecutive key words (start address, length).
- The controller grants one requester at a time, drives ROM en/addr, and streams the returned words on a shared key bus with valid/last markers.
- It sits between the AES key-schedule consumers and the ROM_key instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_BITS, 5, ROM address width (32 words).
- DATA_WIDTH, 128, key word width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until matching done pulse.
- req_addr  in  NUM_REQ*ADDR_BITS  start address, requester i at slice [i*ADDR_BITS +: ADDR_BITS].
- req_len  in  NUM_REQ*ADDR_BITS  burst length minus 1 (0 = 1 word, 31 = 32 words), same slicing.
- grant  out  NUM_REQ  one-hot owner of the current burst.
- done  out  NUM_REQ  one-cycle pulse to the owner coincident with its last word.
- key_data  out  DATA_WIDTH  current key word (combinational pass of rom_dout).
- key_valid  out  1  key_data holds a burst word this cycle.
- key_last  out  1  final word of the burst.
- busy  out  1  state != IDLE.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_BITS  ROM address.
- rom_dout  in  DATA_WIDTH  ROM registered output. Valid one cycle after rom_en=1; zero one cycle after rom_en=0.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE; the RR pointer goes to 0.
  - grant, done, key_valid, key_last, busy, rom_en, rom_addr are all 0.
  - Reset mid-burst aborts the burst. No done pulse is issued, and the requester must re-request.
- States:
  - IDLE: sample req.
    - If any bit is set, pick the winner by round-robin: search from index ptr upward, wrapping at NUM_REQ.
    - Latch the winner's req_addr into cur_addr and req_len into cnt, set grant one-hot, then go to BURST.
    - With no request, stay in IDLE with all outputs 0.
  - BURST: rom_en=1, rom_addr=cur_addr.
    - Each cycle: cur_addr <= cur_addr+1 modulo 2^ADDR_BITS (address 31 wraps to 0); cnt <= cnt-1.
    - When cnt==0 in this cycle (last address issued), go to DRAIN.
  - DRAIN: rom_en=0; last word is on rom_dout. Assert key_valid, key_last, and done[winner]. Set ptr <= winner+1 modulo NUM_REQ, then go to IDLE.
- Data timing:
  - key_valid is rom_en registered by one cycle. key_last is the registered "cnt==0 in BURST" flag.
  - key_data=rom_dout unmodified. Its value is don't-care when key_valid=0; in practice it is 0 per ROM behaviour.
- Latency: req rises in cycle T (controller in IDLE).
  - BURST occupies cycles T+1..T+1+len.
  - First key_valid is in cycle T+2. Last word and done are in cycle T+2+len.
  - Burst of len+1 words occupies len+3 cycles incl. IDLE arbitration. Consecutive bursts have exactly one idle gap cycle (IDLE).
- grant is held constant from BURST entry through DRAIN. It clears in IDLE.
- req changes, or other requesters asserting, during BURST/DRAIN are ignored until the next IDLE.
- req_addr/req_len are sampled only at arbitration; later changes have no effect.
- Requester whose req stays high after done competes again in the next IDLE under RR order. No requester may win twice in a row while another is requesting.

Decomposition:
- Shared package key_ctrl_pkg holds the state enum (IDLE, BURST, DRAIN), the default ADDR_BITS/DATA_WIDTH constants, and the ROM depth constant 32.
- One sub-module, rr_arbiter (NUM_REQ-wide), contains:
  - inputs: req, ptr
  - outputs: one-hot gnt, encoded idx, any
  - purely combinational.
- Controller holds FSM, counters, pointer. The testbench instantiates ROM_key alongside it.

Test Plan:
- Single word: req[0]=1, addr 2, len 0 → grant=0001 at T+1; key_valid/key_last/done[0] at T+2 with key_data=128'h2b7e151628aed2a6abf7158809cf4f3c; busy low at T+3.
- Wrap burst: req[1], addr 30, len 2 → rom_addr 30,31,0. Words in order:
  - 128'h7b0c785e27e8ad3f8223207104725dd4
  - 128'h6bc1bee22e409f96e93d7e117393172a
  - 128'hf69f2445df4f9b17ad2b417be66c3710
  - key_last only on the third.
- Full 32-word burst: req[2], addr 4, len 31 → 32 consecutive valid cycles. First word is 128'h603deb1015ca71be2b73aef0857d7781; addresses 4..31,0..3; one done pulse.
- Round-robin: req=1111 held, each len 0 → grant order 0,1,2,3,0. Each burst is 3 cycles apart in start time, with one IDLE cycle between.
- Reset mid-burst: rst=1 during BURST of len 7 → next cycle all outputs 0 and state IDLE. No done pulse and no further key_valid. After release, ptr=0 so requester 0 wins.
- Late changes ignored: req[3] deasserted and req_addr changed mid-burst → burst completes with original addresses; done[3] still pulses.
